// File: rtl/l2_port_scheduler.sv
// l2_port_scheduler: registered arbiter sharing one L2 port between the
// icache and dcache, dcache first with a bounded icache starvation window.
module l2_port_scheduler #(
    parameter int STARVE_LIMIT = 2,
    parameter int CNT_W        = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_pmem_read,
    input  logic         i_pmem_write,
    input  logic [15:0]  i_pmem_address,
    input  logic [127:0] i_pmem_wdata,
    output logic [127:0] i_pmem_rdata,
    output logic         i_pmem_resp,
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic [127:0] d_pmem_rdata,
    output logic         d_pmem_resp,
    input  logic [127:0] L2_rdata,
    input  logic         L2_resp,
    output logic         L2_read,
    output logic         L2_write,
    output logic [15:0]  L2_address,
    output logic [127:0] L2_wdata
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        TURN
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   starve_q, starve_nx;
    logic               side_d_q, side_d_nx;
    logic               op_wr_q, op_wr_nx;
    logic [15:0]        addr_q, addr_nx;
    logic [127:0]       wdata_q, wdata_nx;
    logic [127:0]       i_rdata_q, d_rdata_q;
    logic               i_pend, d_pend, pick_i, granted;

    assign i_pend = i_pmem_read | i_pmem_write;
    assign d_pend = d_pmem_read | d_pmem_write;
    assign pick_i = i_pend & (~d_pend | (starve_q == LIMIT));

    always_comb begin
        state_nx  = state;
        starve_nx = starve_q;
        side_d_nx = side_d_q;
        op_wr_nx  = op_wr_q;
        addr_nx   = addr_q;
        wdata_nx  = wdata_q;
        unique case (state)
            IDLE: begin
                if (pick_i) begin
                    state_nx  = GRANT_I;
                    side_d_nx = 1'b0;
                    op_wr_nx  = i_pmem_write;
                    addr_nx   = i_pmem_address;
                    wdata_nx  = i_pmem_wdata;
                    starve_nx = '0;
                end else if (d_pend) begin
                    state_nx  = GRANT_D;
                    side_d_nx = 1'b1;
                    op_wr_nx  = d_pmem_write;
                    addr_nx   = d_pmem_address;
                    wdata_nx  = d_pmem_wdata;
                    // only count dcache wins that made a waiting icache lose
                    if (!i_pend)
                        starve_nx = '0;
                    else if (starve_q != LIMIT)
                        starve_nx = starve_q + CNT_W'(1);
                end
            end
            GRANT_I, GRANT_D: begin
                if (L2_resp)
                    state_nx = TURN;
            end
            TURN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            starve_q <= '0;
            side_d_q <= 1'b0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nx;
            starve_q <= starve_nx;
            side_d_q <= side_d_nx;
            op_wr_q  <= op_wr_nx;
            addr_q   <= addr_nx;
            wdata_q  <= wdata_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (L2_resp && !op_wr_q) begin
            if (state == GRANT_I)
                i_rdata_q <= L2_rdata;
            if (state == GRANT_D)
                d_rdata_q <= L2_rdata;
        end
    end

    assign granted      = (state == GRANT_I) | (state == GRANT_D);
    assign L2_read      = granted & ~op_wr_q;
    assign L2_write     = granted & op_wr_q;
    assign L2_address   = addr_q;
    assign L2_wdata     = wdata_q;
    assign i_pmem_resp  = (state == TURN) & ~side_d_q;
    assign d_pmem_resp  = (state == TURN) & side_d_q;
    assign i_pmem_rdata = i_rdata_q;
    assign d_pmem_rdata = d_rdata_q;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// tb_l2_port_scheduler: directed and random traffic against a
// transaction-level model of the shared L2 port.
module tb_l2_port_scheduler;

    localparam int LIMIT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_pmem_read, i_pmem_write;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_wdata, i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read, d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata, d_pmem_rdata;
    logic         d_pmem_resp;
    logic [127:0] L2_rdata, L2_wdata;
    logic         L2_resp, L2_read, L2_write;
    logic [15:0]  L2_address;

    always #5 clk = ~clk;

    l2_port_scheduler #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .L2_rdata(L2_rdata), .L2_resp(L2_resp),
        .L2_read(L2_read), .L2_write(L2_write),
        .L2_address(L2_address), .L2_wdata(L2_wdata)
    );

    int checks = 0;
    int failures = 0;

    // model: who owns the port, who gets the completion pulse this cycle
    int           owner, done_side, starve;
    logic         m_wr;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    logic [127:0] m_rdata [1:2];

    int           obs_log[$];
    int           i_resp_seen, d_resp_seen;
    int           l2_lat, held, d_repeat;
    bit           rand_lat, rand_agents, stray_next, d_rearm, fill_rand;
    logic [127:0] fill;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic new_req(input bit is_d);
        int op;
        op = $urandom_range(0, 3);
        if (is_d) begin
            d_pmem_read    = (op != 2);
            d_pmem_write   = (op >= 2);
            d_pmem_address = 16'($urandom);
            d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            i_pmem_read    = (op != 2);
            i_pmem_write   = (op >= 2);
            i_pmem_address = 16'($urandom);
            i_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic step();
        logic         ip, dp, iw, dw, p_resp;
        logic [15:0]  ia, da;
        logic [127:0] iwd, dwd, p_fill;
        int           win;
        bit           i_drop, d_drop;
        ip = i_pmem_read | i_pmem_write;
        dp = d_pmem_read | d_pmem_write;
        iw = i_pmem_write;   dw = d_pmem_write;
        ia = i_pmem_address; da = d_pmem_address;
        iwd = i_pmem_wdata;  dwd = d_pmem_wdata;
        p_resp = L2_resp;    p_fill = L2_rdata;
        @(posedge clk);
        #1;
        if (owner != 0) begin
            if (p_resp) begin
                if (!m_wr)
                    m_rdata[owner] = p_fill;
                done_side = owner;
                owner = 0;
            end
        end else if (done_side != 0) begin
            done_side = 0;
        end else begin
            win = 0;
            if (ip && (!dp || starve == LIMIT))
                win = 1;
            else if (dp)
                win = 2;
            if (win == 1) begin
                owner = 1; m_wr = iw; m_addr = ia; m_wdata = iwd;
                starve = 0;
            end else if (win == 2) begin
                owner = 2; m_wr = dw; m_addr = da; m_wdata = dwd;
                starve = ip ? ((starve < LIMIT) ? starve + 1 : starve) : 0;
            end
        end
        chk1("l2_read", L2_read, owner != 0 && !m_wr);
        chk1("l2_write", L2_write, owner != 0 && m_wr);
        chk("l2_addr", {112'b0, L2_address}, {112'b0, m_addr});
        chk("l2_wdata", L2_wdata, m_wdata);
        chk1("i_resp", i_pmem_resp, done_side == 1);
        chk1("d_resp", d_pmem_resp, done_side == 2);
        chk("i_rdata", i_pmem_rdata, m_rdata[1]);
        chk("d_rdata", d_pmem_rdata, m_rdata[2]);
        i_drop = 1'b0;
        d_drop = 1'b0;
        if (i_pmem_resp === 1'b1) begin
            i_resp_seen++; obs_log.push_back(1);
            i_pmem_read = 0; i_pmem_write = 0; i_drop = 1'b1;
        end
        if (d_rearm) begin
            d_rearm = 1'b0;
            d_pmem_read = 1'b1;
            d_pmem_address = 16'($urandom);
        end
        if (d_pmem_resp === 1'b1) begin
            d_resp_seen++; obs_log.push_back(2);
            d_pmem_read = 0; d_pmem_write = 0; d_drop = 1'b1;
            if (d_repeat > 0) begin
                d_repeat--;
                d_rearm = 1'b1;
            end
        end
        if (rand_agents) begin
            if (!i_drop && !i_pmem_read && !i_pmem_write &&
                $urandom_range(0, 3) == 0)
                new_req(1'b0);
            if (!d_drop && !d_pmem_read && !d_pmem_write &&
                $urandom_range(0, 2) == 0)
                new_req(1'b1);
        end
        if (owner != 0) begin
            held++;
            if (held == 1 && rand_lat)
                l2_lat = $urandom_range(1, 4);
            L2_resp = (held >= l2_lat);
        end else begin
            held = 0;
            L2_resp = stray_next || (rand_agents && $urandom_range(0, 9) == 0);
            stray_next = 1'b0;
        end
        L2_rdata = fill_rand ? {$urandom, $urandom, $urandom, $urandom} : fill;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk1("rst_l2_read", L2_read, 1'b0);
        chk1("rst_l2_write", L2_write, 1'b0);
        chk1("rst_i_resp", i_pmem_resp, 1'b0);
        chk1("rst_d_resp", d_pmem_resp, 1'b0);
        chk("rst_i_rdata", i_pmem_rdata, 128'b0);
        chk("rst_d_rdata", d_pmem_rdata, 128'b0);
        chk("rst_l2_addr", {112'b0, L2_address}, 128'b0);
        chk("rst_l2_wdata", L2_wdata, 128'b0);
        owner = 0; done_side = 0; starve = 0; held = 0;
        m_wr = 0; m_addr = '0; m_wdata = '0;
        m_rdata[1] = '0; m_rdata[2] = '0;
        i_pmem_read = 0; i_pmem_write = 0;
        d_pmem_read = 0; d_pmem_write = 0;
        L2_resp = 0; d_repeat = 0; d_rearm = 0; stray_next = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int rd_cycles, i_before, d_before;
        reset = 0;
        i_pmem_read = 0; i_pmem_write = 0;
        i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 0; d_pmem_write = 0;
        d_pmem_address = '0; d_pmem_wdata = '0;
        L2_resp = 0; L2_rdata = '0;
        rand_lat = 0; rand_agents = 0; fill_rand = 0; fill = '0;
        l2_lat = 1; i_resp_seen = 0; d_resp_seen = 0;
        #2;
        do_reset();

        // icache read, L2 answers in the fourth strobe cycle
        fill = {16{8'hA5}};
        l2_lat = 4;
        i_pmem_read = 1; i_pmem_address = 16'h1230;
        rd_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (L2_read === 1'b1) rd_cycles++;
        end
        chk("t1_read_cycles", 128'(rd_cycles), 128'd4);
        chk("t1_i_rdata", i_pmem_rdata, {16{8'hA5}});
        chk("t1_no_d_resp", 128'(d_resp_seen), 128'd0);

        // simultaneous: dcache write first, then icache read
        obs_log.delete();
        fill = {4{32'h1234_5678}};
        l2_lat = 1;
        i_pmem_read = 1; i_pmem_address = 16'h0040;
        d_pmem_write = 1; d_pmem_address = 16'h8000; d_pmem_wdata = 128'h1;
        step();
        chk1("t2_l2_write", L2_write, 1'b1);
        chk("t2_l2_wdata", L2_wdata, 128'h1);
        chk("t2_l2_addr", {112'b0, L2_address}, {112'b0, 16'h8000});
        for (int k = 0; k < 8; k++) step();
        chk("t2_d_rdata", d_pmem_rdata, 128'b0);
        chk("t2_order0", 128'(obs_log[0]), 128'd2);
        chk("t2_order1", 128'(obs_log[1]), 128'd1);

        // starvation window: D, D, then icache forced through
        obs_log.delete();
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_read = 1; d_pmem_address = 16'h0200;
        d_repeat = 3;
        for (int k = 0; k < 25; k++) step();
        chk("t3_count", 128'(obs_log.size()), 128'd5);
        chk("t3_order0", 128'(obs_log[0]), 128'd2);
        chk("t3_order1", 128'(obs_log[1]), 128'd2);
        chk("t3_order2", 128'(obs_log[2]), 128'd1);

        // inputs changing during a grant are ignored
        obs_log.delete();
        l2_lat = 3;
        i_pmem_read = 1; i_pmem_address = 16'h2000;
        step();
        i_pmem_address = 16'hFFFF;
        d_pmem_read = 1; d_pmem_address = 16'h3000;
        step();
        chk("t4_addr_held", {112'b0, L2_address}, {112'b0, 16'h2000});
        for (int k = 0; k < 10; k++) step();
        chk("t4_order0", 128'(obs_log[0]), 128'd1);
        chk("t4_order1", 128'(obs_log[1]), 128'd2);

        // stray L2_resp while idle
        i_before = i_resp_seen;
        d_before = d_resp_seen;
        stray_next = 1;
        for (int k = 0; k < 4; k++) step();
        chk("t5_stray", 128'(i_resp_seen + d_resp_seen),
            128'(i_before + d_before));

        // read and write together: write wins
        l2_lat = 2;
        i_pmem_read = 1; i_pmem_write = 1;
        i_pmem_address = 16'h5555; i_pmem_wdata = {4{32'hCAFE_F00D}};
        step();
        chk1("t6_write", L2_write, 1'b1);
        chk1("t6_read", L2_read, 1'b0);
        for (int k = 0; k < 5; k++) step();

        // reset in the middle of a dcache grant
        l2_lat = 10;
        d_pmem_read = 1; d_pmem_address = 16'h4444;
        step();
        step();
        chk1("t7_pre_rst_read", L2_read, 1'b1);
        do_reset();
        for (int k = 0; k < 3; k++) step();

        // random traffic
        rand_agents = 1; rand_lat = 1; fill_rand = 1;
        for (int k = 0; k < 3000; k++) step();
        rand_agents = 0;
        for (int k = 0; k < 20; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_port_scheduler.md
Name: l2_port_scheduler

Overview:
- Shares the single L2 port between the icache and dcache miss/write-back interfaces of the L1 cache pair.
- It replaces direct combinational steering with a registered grant FSM. The FSM latches the winning request's address and write data, and holds the grant until L2_resp.
- Each requester gets a one-cycle response pulse with its own held read-data register.
- Policy is dcache priority, with a starvation limit that guarantees icache progress.

Parameters:
STARVE_LIMIT, 2, consecutive dcache grants allowed while icache waits before icache is forced to win
CNT_W, 2, width of starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_pmem_read  in  1  icache L2 read request
i_pmem_write  in  1  icache L2 write request
i_pmem_address  in  16  icache line address
i_pmem_wdata  in  128  icache write line
i_pmem_rdata  out  128  line returned to icache
i_pmem_resp  out  1  icache completion pulse
d_pmem_read  in  1  dcache L2 read request
d_pmem_write  in  1  dcache L2 write (write-back) request
d_pmem_address  in  16  dcache line address
d_pmem_wdata  in  128  dcache write-back line
d_pmem_rdata  out  128  line returned to dcache
d_pmem_resp  out  1  dcache completion pulse
L2_rdata  in  128  line from L2
L2_resp  in  1  L2 completion
L2_read  out  1  L2 read strobe
L2_write  out  1  L2 write strobe
L2_address  out  16  latched address of granted request
L2_wdata  out  128  latched write data of granted request

Behaviour:
- Reset (async, active-high):
  - State = IDLE; starvation counter = 0.
  - All strobes and resp outputs = 0.
  - L2_address, L2_wdata, i_pmem_rdata and d_pmem_rdata = 0.
- States: IDLE, GRANT_I, GRANT_D, TURN.
- IDLE:
  - A requester is pending if its read or write input is high.
  - Selection rules:
    - Only one requester pending: grant it.
    - Both pending and counter == STARVE_LIMIT: grant icache.
    - Otherwise (both pending, counter below limit): grant dcache.
  - On grant, latch that requester's address, wdata and op into internal registers. If read and write are both high, write wins.
  - Counter: +1 on a dcache grant while icache is pending (saturating at STARVE_LIMIT). Cleared on any icache grant, or on a dcache grant with icache idle.
- GRANT_I / GRANT_D:
  - L2_read or L2_write asserted from the latched op.
  - L2_address and L2_wdata are driven from the latched registers, stable for the whole grant.
  - Requester inputs are ignored while granted.
  - Stay until L2_resp=1. On that edge, capture L2_rdata into the granted side's rdata register (reads only; writes leave it unchanged) and go to TURN.
- TURN (exactly one cycle):
  - L2_read = L2_write = 0.
  - Granted side's *_pmem_resp = 1. The other side's resp = 0.
  - Next state is IDLE.
- Requester protocol:
  - A requester holds read/write and its address/wdata stable until it sees resp, then deasserts in the following cycle.
  - IDLE re-samples one cycle after TURN, so a completed requester is never regranted spuriously.
- Latency:
  - Request high in IDLE at cycle 0 → strobe at cycle 1.
  - L2_resp at cycle n → resp pulse at cycle n+1 → IDLE at n+2.
  - Minimum 3 cycles per transaction when L2_resp arrives in the first grant cycle.
- Hold rules:
  - *_pmem_rdata holds its value until the next read completion for that side.
  - resp outputs are registered (driven by state), never combinational from L2_resp.
- L2_resp outside GRANT_x is ignored.
- Reset mid-grant: the transaction is abandoned and outputs return to reset values immediately. The caches are reset by the same signal.

Test Plan:
- Reset → L2_read=L2_write=0, i/d_pmem_resp=0, rdata=0. Assert reset mid-GRANT_D → strobes drop asynchronously, state IDLE.
- icache read only, address 16'h1230, L2_resp 4 cycles after strobe with L2_rdata=128'hA5..A5 → L2_read=1 and L2_address=16'h1230 for 4 cycles. Then i_pmem_resp=1 for one cycle, i_pmem_rdata=128'hA5..A5 held afterwards, d_pmem_resp never asserted.
- Simultaneous i read 16'h0040 and d write 16'h8000 with wdata 128'h1 → dcache granted first (L2_write=1, L2_wdata=1, d_pmem_rdata unchanged). icache granted after TURN+IDLE.
- Starvation with STARVE_LIMIT=2: icache pending continuously while dcache re-requests back-to-back → grant order D, D, I. Counter returns to 0 after the I grant.
- While GRANT_I, change i_pmem_address to 16'hFFFF and assert d_pmem_read → L2_address stays at the latched value and no regrant occurs until TURN. A stray L2_resp pulse in IDLE produces no resp.
- Requester with both read and write high → L2_write=1 only, L2_read=0.
